// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared BCD constants and helpers for the BCD counter family.
//   BCD_MAX / BCD_ZERO : decade limits
//   bcd_sat()          : clamp a raw nibble to a legal BCD digit (0..9)
//   bcd_all_nines()    : all-nines pattern for up to 8 decades, digit 0 in [3:0]
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic [3:0] bcd_sat(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

    // Returned at full 32-bit width; callers slice the low 4*digits bits.
    function automatic logic [31:0] bcd_all_nines(input int digits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < digits) r[4*i +: 4] = BCD_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// ---------------------------------------------------------------------------
// bcd_digit_dec
// Combinational single-decade decrement stage.
//   digit      : current BCD digit
//   borrow_in  : 1 = this decade must decrement
//   next_digit : decremented (or unchanged) digit
//   borrow_out : 1 = this decade rolled 0 -> 9 and borrows from the next one
// ---------------------------------------------------------------------------
module bcd_digit_dec
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    // NOTE: every output gets a default before the if-tree so no path can
    // leave a value unassigned, which would otherwise infer a latch.
    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == BCD_ZERO) begin
                next_digit = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_sync_down_cntr.sv
// ---------------------------------------------------------------------------
// bcd_sync_down_cntr
// Synchronous DIGITS-decade packed-BCD down counter with parallel load,
// terminal-count flag and cascade borrow.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   load     : parallel load strobe (beats cnt_en)
//   load_val : packed BCD load value, digit 0 in [3:0]; digits > 9 clamp to 9
//   cnt_en   : decrement enable
//   count    : registered packed BCD count
//   zero     : count == 0 (decode of the register)
//   done     : one-cycle pulse after a 1 -> 0 step
//   borrow   : one-cycle pulse after a 0 -> all-nines wrap (WRAP=1)
//   load_err : one-cycle pulse after a load that contained an illegal digit
// ---------------------------------------------------------------------------
module bcd_sync_down_cntr
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                cnt_en,
    output logic [4*DIGITS-1:0] count,
    output logic                zero,
    output logic                done,
    output logic                borrow,
    output logic                load_err
);

    localparam int          W         = 4 * DIGITS;
    localparam logic [31:0] NINES_32  = bcd_all_nines(DIGITS);
    localparam logic [W-1:0] ALL_NINES = NINES_32[W-1:0];
    localparam logic [W-1:0] COUNT_ONE = W'(1);

    logic [W-1:0]    dec_val;
    logic [DIGITS:0] chain;
    logic [W-1:0]    load_clamped;
    logic            load_bad;
    logic            at_zero;

    // Digit 0 always decrements; each stage passes its borrow upward.
    assign chain[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_digit_dec u_dec (
            .digit      (count[4*g +: 4]),
            .borrow_in  (chain[g]),
            .next_digit (dec_val[4*g +: 4]),
            .borrow_out (chain[g+1])
        );
    end

    // A borrow out of the top decade means every decade was 0.
    assign at_zero = chain[DIGITS];
    assign zero    = (count == '0);

    always_comb begin
        load_clamped = '0;
        load_bad     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = bcd_sat(load_val[4*i +: 4]);
            if (load_val[4*i +: 4] > BCD_MAX) load_bad = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            done     <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            // Flags are pulses: cleared unless this edge re-raises them.
            done     <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                count    <= load_clamped;
                load_err <= load_bad;
            end else if (cnt_en) begin
                if (at_zero) begin
                    if (WRAP) begin
                        count  <= ALL_NINES;
                        borrow <= 1'b1;
                    end
                end else begin
                    count <= dec_val;
                    done  <= (count == COUNT_ONE);
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_sync_down_cntr.sv
// ---------------------------------------------------------------------------
// tb_bcd_sync_down_cntr
// Two counters (WRAP=1 and WRAP=0) share one stimulus stream. The driver
// computes each expected post-edge response from an integer model and queues
// it; a monitor samples both DUTs after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_bcd_sync_down_cntr;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 99;

    typedef struct packed {
        logic [W-1:0] count;
        logic         zero;
        logic         done;
        logic         borrow;
        logic         load_err;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] load_val;
    logic         cnt_en;

    logic [W-1:0] count_w1, count_w0;
    logic         zero_w1, done_w1, borrow_w1, lerr_w1;
    logic         zero_w0, done_w0, borrow_w0, lerr_w0;

    resp_t q_w1[$];
    resp_t q_w0[$];
    int    val_w1, val_w0;
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    bcd_sync_down_cntr #(.DIGITS(DIGITS), .WRAP(1'b1)) dut_w1 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .cnt_en(cnt_en),
        .count(count_w1), .zero(zero_w1), .done(done_w1), .borrow(borrow_w1),
        .load_err(lerr_w1)
    );

    bcd_sync_down_cntr #(.DIGITS(DIGITS), .WRAP(1'b0)) dut_w0 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .cnt_en(cnt_en),
        .count(count_w0), .zero(zero_w0), .done(done_w0), .borrow(borrow_w0),
        .load_err(lerr_w0)
    );

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Counter behaviour in plain decimal arithmetic.
    function automatic resp_t model(input int v, input bit r, input bit ld,
                                    input logic [W-1:0] lv, input bit en,
                                    input bit wrap, output int v_next);
        resp_t e;
        int    nv;
        int    dg;
        e  = '0;
        nv = v;
        if (r) begin
            nv = 0;
        end else if (ld) begin
            nv = 0;
            for (int i = DIGITS - 1; i >= 0; i--) begin
                dg = int'(lv[4*i +: 4]);
                if (dg > 9) begin
                    dg = 9;
                    e.load_err = 1'b1;
                end
                nv = nv * 10 + dg;
            end
        end else if (en) begin
            if (v == 0) begin
                if (wrap) begin
                    nv       = MAXV;
                    e.borrow = 1'b1;
                end
            end else begin
                nv     = v - 1;
                e.done = (v == 1);
            end
        end
        e.count = to_bcd(nv);
        e.zero  = (nv == 0);
        v_next  = nv;
        return e;
    endfunction

    task automatic check(input string name, input resp_t act, input resp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got count=%h zero=%b done=%b borrow=%b load_err=%b, expected count=%h zero=%b done=%b borrow=%b load_err=%b",
                     name, $time, act.count, act.zero, act.done, act.borrow, act.load_err,
                     exp.count, exp.zero, exp.done, exp.borrow, exp.load_err);
        end
    endtask

    // Drive one edge worth of inputs and queue the expected responses.
    task automatic cycle(input bit r, input bit ld, input logic [W-1:0] lv, input bit en);
        int nv;
        @(negedge clk);
        rst      = r;
        load     = ld;
        load_val = lv;
        cnt_en   = en;
        q_w1.push_back(model(val_w1, r, ld, lv, en, 1'b1, nv));
        val_w1 = nv;
        q_w0.push_back(model(val_w0, r, ld, lv, en, 1'b0, nv));
        val_w0 = nv;
    endtask

    // Monitor: one sample per rising edge, away from the edge itself.
    initial begin
        resp_t act;
        forever begin
            @(posedge clk);
            #1;
            if (q_w1.size() > 0) begin
                act = '{count_w1, zero_w1, done_w1, borrow_w1, lerr_w1};
                check("wrap1", act, q_w1.pop_front());
            end
            if (q_w0.size() > 0) begin
                act = '{count_w0, zero_w0, done_w0, borrow_w0, lerr_w0};
                check("wrap0", act, q_w0.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load = 1'b1; load_val = 8'h55; cnt_en = 1'b1;
        val_w1 = 0;
        val_w0 = 0;

        // Reset beats load and cnt_en.
        repeat (2) cycle(1'b1, 1'b1, 8'h55, 1'b1);

        // Countdown 12 -> 00 (includes the 10 -> 09 tens borrow and done).
        cycle(1'b0, 1'b1, 8'h12, 1'b0);
        repeat (12) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // At zero: WRAP=1 goes 99 then 98; WRAP=0 holds for five edges.
        repeat (5) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Hold with enable low.
        repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Load priority and clamp: 45, then load A3 with cnt_en high -> 93.
        cycle(1'b0, 1'b1, 8'h45, 1'b0);
        cycle(1'b0, 1'b1, 8'hA3, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 8'hFF, 1'b0);

        // Back-to-back done then borrow from count 01.
        cycle(1'b0, 1'b1, 8'h01, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Mid-count reset with enable held, then resume.
        cycle(1'b0, 1'b1, 8'h37, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic; small load values make terminal events frequent.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] lv;
            lv = W'($urandom);
            if ($urandom_range(0, 1) == 0) lv = W'($urandom_range(0, 3));
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) == 0),
                  lv,
                  ($urandom_range(0, 9) < 7));
        end

        // Let the monitor drain the last expectations.
        repeat (3) @(negedge clk);
        n_checks++;
        if (q_w1.size() != 0 || q_w0.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", q_w1.size(), q_w0.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
